// File: rtl/dmx_rx.sv
// DMX512 receiver: 16x oversampled UART framing with break detection and slot numbering.
// All timing advances on baudEn; strobes are registered one-clk pulses.
module dmx_rx #(
  parameter int unsigned BRK_TICKS = 352,
  parameter int unsigned MAX_SLOT  = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baudEn,
  input  logic       rxd,
  output logic [8:0] data,
  output logic [9:0] slot,
  output logic       valid,
  output logic       brk,
  output logic       ferr
);

  localparam logic [8:0]  BrkTicksW = 9'(BRK_TICKS);
  localparam logic [10:0] MaxSlotW  = 11'(MAX_SLOT);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  state_e      state_q, state_d;
  logic [1:0]  sync_q;
  logic        rxs;
  logic [3:0]  ph_q, ph_d;
  logic [2:0]  bitnum_q, bitnum_d;
  logic [7:0]  shift_q, shift_d;
  logic [8:0]  low_cnt_q;
  logic        cand_q, cand_d;
  logic        seen_q;
  logic [10:0] nslot_q;
  logic        valid_d, brk_d, ferr_d;

  assign rxs = sync_q[1];

  // State register: FSM, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sync_q    <= 2'b11;
      ph_q      <= 4'd0;
      bitnum_q  <= 3'd0;
      shift_q   <= 8'd0;
      low_cnt_q <= 9'd0;
      cand_q    <= 1'b0;
      seen_q    <= 1'b0;
      nslot_q   <= 11'd0;
      data      <= 9'd0;
      slot      <= 10'd0;
      valid     <= 1'b0;
      brk       <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      valid <= valid_d;
      brk   <= brk_d;
      ferr  <= ferr_d;
      if (baudEn) begin
        sync_q   <= {sync_q[0], rxd};
        state_q  <= state_d;
        ph_q     <= ph_d;
        bitnum_q <= bitnum_d;
        shift_q  <= shift_d;
        cand_q   <= cand_d;
        if (!rxs) begin
          if (low_cnt_q != 9'd511) low_cnt_q <= low_cnt_q + 9'd1;
        end else begin
          low_cnt_q <= 9'd0;
        end
      end
      if (brk_d) begin
        seen_q  <= 1'b1;
        nslot_q <= 11'd0;
      end
      if (valid_d) begin
        data    <= {(nslot_q == 11'd0), shift_q};
        slot    <= nslot_q[9:0];
        nslot_q <= nslot_q + 11'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    bitnum_d = bitnum_q;
    shift_d  = shift_q;
    cand_d   = cand_q;
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          state_d = StStart;
          ph_d    = 4'd0;
        end
      end
      StStart: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd7) begin
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d  = StData;
            bitnum_d = 3'd0;
          end
        end
      end
      StData: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd7) begin
          shift_d  = {rxs, shift_q[7:1]};
          bitnum_d = bitnum_q + 3'd1;
          if (bitnum_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd7) begin
          if (rxs) begin
            state_d = StIdle;
          end else begin
            state_d = StWaitHi;
            // An all-zero byte with a low stop bit may be the start of a break.
            cand_d  = (shift_q == 8'd0);
          end
        end
      end
      StWaitHi: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!baudEn) begin
      state_d  = state_q;
      ph_d     = ph_q;
      bitnum_d = bitnum_q;
      shift_d  = shift_q;
      cand_d   = cand_q;
    end
  end

  // Strobe decode, registered in the state process.
  always_comb begin
    valid_d = 1'b0;
    brk_d   = 1'b0;
    ferr_d  = 1'b0;
    if (baudEn) begin
      unique case (state_q)
        StStop: begin
          if (ph_q == 4'd7) begin
            if (rxs) valid_d = seen_q && (nslot_q <= MaxSlotW);
            else if (shift_q != 8'd0) ferr_d = 1'b1;
          end
        end
        StWaitHi: begin
          if (rxs) begin
            if (low_cnt_q >= BrkTicksW) brk_d = 1'b1;
            else if (cand_q) ferr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmx_rx.md
DMX_RX -- requirements
Module: dmx_rx

Interface
REQ-001 SHALL have parameter BRK_TICKS, default 352, meaning the minimum number of consecutive low baudEn ticks accepted as a break (22 bit times at 16x).
REQ-002 SHALL have parameter MAX_SLOT, default 512, meaning the highest data slot number delivered after the start code.
REQ-003 SHALL have port clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port baudEn  input  1  single-clk enable at 16x the 250 kbaud rate.
REQ-006 SHALL have port rxd  input  1  asynchronous DMX serial data in, idle high.
REQ-007 SHALL have port data  output  9  received byte in [7:0]; [8] set only for the start code (first slot after a break).
REQ-008 SHALL have port slot  output  10  slot number of data: 0 for the start code, 1..MAX_SLOT for data slots.
REQ-009 SHALL have port valid  output  1  one-clk strobe qualifying data and slot.
REQ-010 SHALL have port brk  output  1  one-clk strobe when a valid break ends.
REQ-011 SHALL have port ferr  output  1  one-clk strobe on framing error or short break.

Function
REQ-012 SHALL synchronize rxd through two flops (reset value 1) before any use; rxs denotes the synchronized value.
REQ-013 SHALL advance all bit timing, sampling and counters only on clk cycles with baudEn=1.
REQ-014 SHALL keep a 9-bit low counter that increments while rxs=0, saturates at 511, and clears on baudEn with rxs=1.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAITHI with 4-bit phase counter ph and bit counter bitnum.
REQ-016 IDLE: on rxs=0 SHALL go to START with ph=0.
REQ-017 START: at ph=7, if rxs=1 SHALL return to IDLE (glitch, no strobe); otherwise SHALL go to DATA with bitnum=0.
REQ-018 DATA: ph SHALL wrap 15->0; at each ph=7 SHALL shift rxs in LSB first; after the 8th sample SHALL go to STOP.
REQ-019 STOP: at ph=7 with rxs=1 SHALL deliver the byte per REQ-022 and go to IDLE.
REQ-020 STOP: at ph=7 with rxs=0 and nonzero byte SHALL pulse ferr and go to WAITHI; with zero byte SHALL go to WAITHI without ferr (break candidate).
REQ-021 WAITHI: on rxs=1, if low counter >= BRK_TICKS SHALL pulse brk, set the break-seen flag, set next slot to 0, and enter IDLE; if below BRK_TICKS and the entry was a break candidate SHALL pulse ferr; either way SHALL enter IDLE.
REQ-022 Delivery: valid SHALL pulse only if break-seen is set and the next slot <= MAX_SLOT; data[8] SHALL be 1 iff slot=0; slot SHALL then increment; bytes beyond MAX_SLOT SHALL be dropped silently.
REQ-023 valid, brk, ferr SHALL be registered, asserted on the clk edge following the deciding baudEn cycle, and never asserted in the same cycle as each other.
REQ-024 data and slot SHALL hold their values until the next valid.
REQ-025 A valid break arriving in any state SHALL restart framing: next delivered byte SHALL be slot 0.
REQ-026 baudEn stuck at 0 SHALL freeze all state; no strobes SHALL occur.

Reset
REQ-027 On rst=1 SHALL immediately force: state IDLE, ph=0, bitnum=0, low counter=0, break-seen=0, synchronizer=1, data=0, slot=0, valid=0, brk=0, ferr=0.
REQ-028 Reset mid-frame SHALL discard the partial byte; bytes before the first subsequent break SHALL not produce valid.

Verification
REQ-029 Break 100 us, MAB 12 us, start code 0x00, slots 0x55, 0xAA -> brk once; valid x3 with data/slot 0x100/0, 0x055/1, 0x0AA/2.
REQ-030 Bytes 0x12, 0x34 with no prior break after reset -> no valid, no ferr.
REQ-031 Low of 60 us (below 352 ticks) after a frame -> ferr once, no brk; next bytes delivered with slot continuing.
REQ-032 Byte 0x3C with stop bit driven 0 -> ferr once, no valid; following correct byte delivered normally.
REQ-033 rxd low pulse of 4 ticks in IDLE -> returns to IDLE, no strobes.
REQ-034 Break + 514 slots with MAX_SLOT=512 -> valid for slots 0..512 only; rst asserted mid-slot 100 -> all outputs 0 immediately, no valid until next break.
